fp_mul_pipe: RTL and testbench

FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

---
 rtl/fp_pkg.sv | 26 ++
 rtl/fp_classify.sv | 40 ++++
 rtl/fp_mul_pipe.sv | 215 +++++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the multiplier slice.
//   - Flag bit positions inside the 5-bit flag vector
//     {invalid, overflow, underflow, inexact, zero}.
//   - Operand class enumeration produced by fp_classify.
//   - fp_bias(): exponent bias for a given exponent field width.
package fp_pkg;

  localparam int FLAG_W         = 5;
  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_OVERFLOW  = 3;
  localparam int FLAG_UNDERFLOW = 2;
  localparam int FLAG_INEXACT   = 1;
  localparam int FLAG_ZERO      = 0;

  typedef enum logic [1:0] {
    FP_ZERO   = 2'd0,
    FP_NORMAL = 2'd1,
    FP_INF    = 2'd2,
    FP_NAN    = 2'd3
  } fp_class_e;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand unpack/classify.
// Ports:
//   op    : {sign, exp, frac} operand
//   sign  : sign bit
//   exp_f : biased exponent field
//   sig   : significand with hidden bit restored (0 for zero/subnormal/inf/nan)
//   cls   : FP_ZERO, FP_NORMAL, FP_INF or FP_NAN
// Subnormals (exp == 0) are flushed and classed as zero.
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op,
  output logic                 sign,
  output logic [EXP_W-1:0]     exp_f,
  output logic [MAN_W:0]       sig,
  output fp_class_e            cls
);

  logic [MAN_W-1:0] frac;

  assign sign  = op[EXP_W+MAN_W];
  assign exp_f = op[MAN_W +: EXP_W];
  assign frac  = op[MAN_W-1:0];

  always_comb begin
    sig = '0;
    cls = FP_NORMAL;
    if (exp_f == '0) begin
      cls = FP_ZERO;
    end else if (&exp_f) begin
      cls = (frac == '0) ? FP_INF : FP_NAN;
    end else begin
      sig = {1'b1, frac};
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier.
//   S1: unpack/classify both operands, decide special results, add exponents
//   S2: significand multiply
//   S3: normalise, round, detect overflow/underflow, pack
// Ports:
//   CLK, RST           : clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready : operand handshake
//   A, B               : operands {sign, exp, frac}
//   out_valid, out_ready : result handshake
//   out_p              : product
//   out_flags          : {invalid, overflow, underflow, inexact, zero}
// Build option: define FP_MUL_ROUND_EN for round-to-nearest-even;
// otherwise results are truncated toward zero (latency identical).
//
// Handshake: a transfer happens on a rising CLK edge where valid && ready are
// both high. The whole pipe moves as one (adv = !out_valid || out_ready), so
// in_ready equals adv and a stalled result keeps out_p/out_flags frozen.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] A,
  input  logic [EXP_W+MAN_W:0] B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_p,
  output logic [FLAG_W-1:0]    out_flags
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 1;
  localparam int PW    = 2 * SIG_W;
  localparam int XW    = EXP_W + 2;
  localparam int BIAS  = fp_bias(EXP_W);
  localparam int EMAX  = (1 << EXP_W) - 1;

  localparam logic signed [XW-1:0] BIAS_X = BIAS[XW-1:0];
  localparam logic signed [XW-1:0] EMAX_X = EMAX[XW-1:0];
  localparam logic signed [XW-1:0] ZERO_X = '0;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- S1: classify ----------------
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W:0]   siga, sigb;
  fp_class_e        ca, cb;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .op(A), .sign(sa), .exp_f(ea), .sig(siga), .cls(ca)
  );
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .op(B), .sign(sb), .exp_f(eb), .sig(sigb), .cls(cb)
  );

  fp_class_e             kind;
  logic                  kind_inv;
  logic signed [XW-1:0]  exp_sum;

  // Result class decided up front; only FP_NORMAL needs the arithmetic path.
  always_comb begin
    kind     = FP_NORMAL;
    kind_inv = 1'b0;
    if (ca == FP_NAN || cb == FP_NAN) begin
      kind = FP_NAN;
    end else if ((ca == FP_INF && cb == FP_ZERO) || (ca == FP_ZERO && cb == FP_INF)) begin
      kind     = FP_NAN;
      kind_inv = 1'b1;
    end else if (ca == FP_INF || cb == FP_INF) begin
      kind = FP_INF;
    end else if (ca == FP_ZERO || cb == FP_ZERO) begin
      kind = FP_ZERO;
    end
  end

  assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_X;

  logic                 s1_v, s1_sign, s1_inv;
  logic signed [XW-1:0] s1_exp;
  logic [MAN_W:0]       s1_sig_a, s1_sig_b;
  fp_class_e            s1_cls;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_v     <= 1'b0;
      s1_sign  <= 1'b0;
      s1_inv   <= 1'b0;
      s1_exp   <= '0;
      s1_sig_a <= '0;
      s1_sig_b <= '0;
      s1_cls   <= FP_ZERO;
    end else if (adv) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_sign  <= sa ^ sb;
        s1_inv   <= kind_inv;
        s1_exp   <= exp_sum;
        s1_sig_a <= siga;
        s1_sig_b <= sigb;
        s1_cls   <= kind;
      end
    end
  end

  // ---------------- S2: multiply ----------------
  logic                 s2_v, s2_sign, s2_inv;
  logic signed [XW-1:0] s2_exp;
  logic [PW-1:0]        s2_prod;
  fp_class_e            s2_cls;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s2_v    <= 1'b0;
      s2_sign <= 1'b0;
      s2_inv  <= 1'b0;
      s2_exp  <= '0;
      s2_prod <= '0;
      s2_cls  <= FP_ZERO;
    end else if (adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_sign <= s1_sign;
        s2_inv  <= s1_inv;
        s2_exp  <= s1_exp;
        s2_prod <= PW'(s1_sig_a) * PW'(s1_sig_b);
        s2_cls  <= s1_cls;
      end
    end
  end

  // ---------------- S3: normalise / round / pack ----------------
  logic                 msb;
  logic [PW-2:0]        norm;      // hidden bit dropped, leading 1 aligned to top
  logic [MAN_W-1:0]     frac_t;
  logic                 guard, sticky, round_up, inexact;
  logic [MAN_W:0]       frac_sum;
  logic signed [XW-1:0] e_n, e_r;
  logic [W-1:0]         res_p;
  logic [FLAG_W-1:0]    res_f;

  always_comb begin
    msb    = s2_prod[PW-1];
    // Product of two [1,2) significands lies in [1,4): shift so the
    // leading one sits just above bit PW-2 in both cases.
    norm   = msb ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
    frac_t = norm[PW-2 -: MAN_W];
    guard  = norm[PW-2-MAN_W];
    sticky = |norm[PW-3-MAN_W:0];
    inexact = guard | sticky;
    e_n    = s2_exp + $signed({{(XW-1){1'b0}}, msb});
`ifdef FP_MUL_ROUND_EN
    round_up = guard & (sticky | frac_t[0]);
`else
    round_up = 1'b0;
`endif
    frac_sum = {1'b0, frac_t} + {{MAN_W{1'b0}}, round_up};
    // Carry out of an all-ones fraction bumps the exponent; fraction wraps to 0.
    e_r = e_n + $signed({{(XW-1){1'b0}}, frac_sum[MAN_W]});

    res_p = '0;
    res_f = '0;
    case (s2_cls)
      FP_NAN: begin
        res_p               = QNAN;
        res_f[FLAG_INVALID] = s2_inv;
      end
      FP_INF: begin
        res_p = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
      FP_ZERO: begin
        res_p            = {s2_sign, {(W-1){1'b0}}};
        res_f[FLAG_ZERO] = 1'b1;
      end
      default: begin
        if (e_r <= ZERO_X) begin
          res_p                 = {s2_sign, {(W-1){1'b0}}};
          res_f[FLAG_UNDERFLOW] = 1'b1;
          res_f[FLAG_ZERO]      = 1'b1;
          res_f[FLAG_INEXACT]   = 1'b1;
        end else if (e_r >= EMAX_X) begin
          res_p                = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          res_f[FLAG_OVERFLOW] = 1'b1;
          res_f[FLAG_INEXACT]  = 1'b1;
        end else begin
          res_p               = {s2_sign, e_r[EXP_W-1:0], frac_sum[MAN_W-1:0]};
          res_f[FLAG_INEXACT] = inexact;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      out_flags <= '0;
    end else if (adv) begin
      out_valid <= s2_v;
      if (s2_v) begin
        out_p     <= res_p;
        out_flags <= res_f;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed self-checking bench for fp_mul_pipe (single precision defaults).
// Inputs are driven and outputs sampled around the falling clock edge.
module tb_fp_mul_pipe;

  logic        CLK;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_p;
  logic [4:0]  out_flags;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_flags(out_flags)
  );

  // ---------------- clock ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One operation through an otherwise idle pipe, checking exact latency.
  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ep, input logic [4:0] ef);
    @(negedge CLK);
    out_ready = 1'b1;
    A = a;
    B = b;
    in_valid = 1'b1;
    #1;
    check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
    @(negedge CLK);
    in_valid = 1'b0;
    check({tag, "/lat1"}, 64'(out_valid), 64'd0);
    @(negedge CLK);
    check({tag, "/lat2"}, 64'(out_valid), 64'd0);
    @(negedge CLK);
    check({tag, "/lat3"}, 64'(out_valid), 64'd1);
    check({tag, "/p"}, 64'(out_p), 64'(ep));
    check({tag, "/flags"}, 64'(out_flags), 64'(ef));
  endtask

  // Flag encodings {invalid, overflow, underflow, inexact, zero}
  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_INV  = 5'b10000;
  localparam logic [4:0] F_OVF  = 5'b01010;
  localparam logic [4:0] F_INX  = 5'b00010;
  localparam logic [4:0] F_UNF  = 5'b00111;
  localparam logic [4:0] F_ZERO = 5'b00001;

  logic [31:0] sa[8], sb[8], sp[8];

  initial begin
    int idx;
    int got;
    logic [31:0] front;

    sa = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
           32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    sb = '{default: 32'h40000000};
    sp = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
           32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};

    // ---------------- reset ----------------
    RST = 1'b1;
    in_valid = 1'b0;
    A = '0;
    B = '0;
    out_ready = 1'b1;
    #2;
    RST = 1'b0;
    #1;
    check("rst/out_valid", 64'(out_valid), 64'd0);
    check("rst/out_p", 64'(out_p), 64'd0);
    check("rst/out_flags", 64'(out_flags), 64'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("rst/in_ready", 64'(in_ready), 64'd1);

    // ---------------- directed vectors ----------------
    run_one("mul_2x3",   32'h40000000, 32'h40400000, 32'h40C00000, F_NONE);
    run_one("inf_x_0",   32'h7F800000, 32'h00000000, 32'h7FC00000, F_INV);
    run_one("ovf",       32'h7F000000, 32'h40000000, 32'h7F800000, F_OVF);
`ifdef FP_MUL_ROUND_EN
    run_one("tie_even",  32'h3F800001, 32'h3FC00000, 32'h3FC00002, F_INX);
    run_one("rnd_carry", 32'h3F800001, 32'h3FFFFFFE, 32'h40000000, F_INX);
    run_one("rnd_ovf",   32'h3F800001, 32'h7F7FFFFE, 32'h7F800000, F_OVF);
`else
    run_one("tie_even",  32'h3F800001, 32'h3FC00000, 32'h3FC00001, F_INX);
    run_one("rnd_carry", 32'h3F800001, 32'h3FFFFFFE, 32'h3FFFFFFF, F_INX);
    run_one("rnd_ovf",   32'h3F800001, 32'h7F7FFFFE, 32'h7F7FFFFF, F_INX);
`endif
    run_one("unf",       32'h00800000, 32'h00800000, 32'h00000000, F_UNF);
    run_one("neg_zero",  32'h80000000, 32'h40000000, 32'h80000000, F_ZERO);
    run_one("nan_in",    32'h7FC12345, 32'h3F800000, 32'h7FC00000, F_NONE);
    run_one("neg_inf",   32'hFF800000, 32'h40000000, 32'hFF800000, F_NONE);
    run_one("neg_mix",   32'hBFC00000, 32'h40200000, 32'hC0700000, F_NONE);
    run_one("min_norm",  32'h3F800000, 32'h00800000, 32'h00800000, F_NONE);
    run_one("e_zero",    32'h3F000000, 32'h00800000, 32'h00000000, F_UNF);
    run_one("subnorm",   32'h00000001, 32'h40000000, 32'h00000000, F_ZERO);

    // ---------------- streaming with back-pressure ----------------
    idx = 0;
    got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge CLK);
      out_ready = !(c >= 4 && c <= 6);
      if (idx < 8) begin
        in_valid = 1'b1;
        A = sa[idx];
        B = sb[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check("stream/in_ready", 64'(in_ready), 64'(out_ready));
      if (in_valid && in_ready) begin
        exp_q.push_back(sp[idx]);
        idx++;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("stream/extra_result", 64'(out_valid), 64'd0);
        end else if (!out_ready) begin
          check("stream/held_p", 64'(out_p), 64'(exp_q[0]));
        end else begin
          front = exp_q.pop_front();
          check("stream/p", 64'(out_p), 64'(front));
          check("stream/flags", 64'(out_flags), 64'(F_NONE));
          got++;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream/count", 64'(got), 64'd8);
    check("stream/leftover", 64'(exp_q.size()), 64'd0);

    // ---------------- reset with operations in flight ----------------
    @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      A = sa[k];
      B = sb[k];
      in_valid = 1'b1;
      @(negedge CLK);
    end
    @(posedge CLK);
    #2;
    in_valid = 1'b0;
    RST = 1'b0;
    #1;
    check("midrst/out_valid", 64'(out_valid), 64'd0);
    check("midrst/out_p", 64'(out_p), 64'd0);
    check("midrst/out_flags", 64'(out_flags), 64'd0);
    check("midrst/in_ready", 64'(in_ready), 64'd1);
    @(negedge CLK);
    RST = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check("midrst/no_stale", 64'(out_valid), 64'd0);
    end
    run_one("post_rst", 32'h40000000, 32'h40400000, 32'h40C00000, F_NONE);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
